// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the supervisor trap sequencer.
package trap_sequencer_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_M = 2'd3
  } priv_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_seq_state_e;

  typedef enum logic [1:0] {
    EV_EXC  = 2'd0,
    EV_IRQ  = 2'd1,
    EV_SRET = 2'd2
  } trap_kind_e;

  localparam logic [4:0] IRQ_SSI = 5'd1;
  localparam logic [4:0] IRQ_STI = 5'd5;
  localparam logic [4:0] IRQ_SEI = 5'd9;

endpackage

// File: rtl/trap_sequencer_irq_sync.sv
// Multi-flop synchronizer bringing the asynchronous external interrupt into clk.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/trap_sequencer.sv
// Supervisor trap sequencer: picks an exception, SRET or interrupt, drains the
// pipeline, commits the trap CSR update and redirects fetch.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  priv_e       cur_priv,
  input  logic        sstatus_sie,
  input  logic [31:0] sie,
  input  logic        sip_ssip,
  input  logic [31:0] time_value,
  input  logic [31:0] stimecmp,
  input  logic        irq_ext_async,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic [31:0] cur_pc,
  input  logic        sret_req,
  input  logic [31:0] stvec,
  input  logic [31:0] sepc,
  output logic        flush_req,
  input  logic        flush_ack,
  output logic        trap_set,
  output logic        trap_is_irq,
  output logic [4:0]  trap_scause,
  output logic [31:0] trap_sepc,
  output logic [31:0] trap_stval,
  output logic        do_sret,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  logic ext_sync;

  irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq_ext_async),
    .q   (ext_sync)
  );

  // Only the SEI/SSI/STI enable bits matter here.
  logic unused_sie;
  assign unused_sie = ^{sie[31:10], sie[8:6], sie[4:2], sie[0]};

  trap_seq_state_e state_q, state_d;
  trap_kind_e      kind_q, kind_d;
  logic [4:0]      cause_q, cause_d;
  logic [31:0]     pc_q, pc_d, tval_q, tval_d, redirect_pc_q, redirect_pc_d;
  logic            flush_req_q, flush_req_d, trap_set_q, trap_set_d;
  logic            is_irq_q, is_irq_d, do_sret_q, do_sret_d;
  logic            redirect_valid_q, redirect_valid_d;

  logic irq_ok, sei, ssi, sti;

  always_comb begin
    irq_ok = (cur_priv == PRIV_U) | ((cur_priv == PRIV_S) & sstatus_sie);
    sei    = sie[IRQ_SEI] & ext_sync;
    ssi    = sie[IRQ_SSI] & sip_ssip;
    sti    = sie[IRQ_STI] & (time_value >= stimecmp);

    state_d          = state_q;
    kind_d           = kind_q;
    cause_d          = cause_q;
    pc_d             = pc_q;
    tval_d           = tval_q;
    redirect_pc_d    = redirect_pc_q;
    flush_req_d      = 1'b0;
    trap_set_d       = 1'b0;
    is_irq_d         = 1'b0;
    do_sret_d        = 1'b0;
    redirect_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          state_d = ST_FLUSH;
          kind_d  = EV_EXC;
          cause_d = exc_cause;
          pc_d    = exc_pc;
          tval_d  = exc_tval;
        end else if (sret_req) begin
          state_d = ST_FLUSH;
          kind_d  = EV_SRET;
        end else if (irq_ok & (sei | ssi | sti)) begin
          state_d = ST_FLUSH;
          kind_d  = EV_IRQ;
          cause_d = sei ? IRQ_SEI : (ssi ? IRQ_SSI : IRQ_STI);
          pc_d    = cur_pc;
          tval_d  = '0;
        end
        flush_req_d = (state_d == ST_FLUSH);
      end
      ST_FLUSH: begin
        if (flush_ack) begin
          state_d    = ST_COMMIT;
          trap_set_d = (kind_q != EV_SRET);
          is_irq_d   = (kind_q == EV_IRQ);
          do_sret_d  = (kind_q == EV_SRET);
        end else begin
          flush_req_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        state_d          = ST_REDIRECT;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = (kind_q == EV_SRET) ? sepc : (stvec & 32'hFFFF_FFFC);
      end
      ST_REDIRECT: begin
        if (redirect_ready) state_d = ST_IDLE;
        else                redirect_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      kind_q           <= EV_EXC;
      cause_q          <= '0;
      pc_q             <= '0;
      tval_q           <= '0;
      redirect_pc_q    <= '0;
      flush_req_q      <= 1'b0;
      trap_set_q       <= 1'b0;
      is_irq_q         <= 1'b0;
      do_sret_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      kind_q           <= kind_d;
      cause_q          <= cause_d;
      pc_q             <= pc_d;
      tval_q           <= tval_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_req_q      <= flush_req_d;
      trap_set_q       <= trap_set_d;
      is_irq_q         <= is_irq_d;
      do_sret_q        <= do_sret_d;
      redirect_valid_q <= redirect_valid_d;
    end
  end

  assign flush_req      = flush_req_q;
  assign trap_set       = trap_set_q;
  assign trap_is_irq    = is_irq_q;
  assign trap_scause    = cause_q;
  assign trap_sepc      = pc_q;
  assign trap_stval     = tval_q;
  assign do_sret        = do_sret_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: exception, interrupt, SRET, stall and reset cases.
module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  logic        clk = 1'b0, rst;
  priv_e       cur_priv;
  logic        sstatus_sie, sip_ssip, irq_ext_async, exc_valid, sret_req;
  logic [31:0] sie, time_value, stimecmp, exc_pc, exc_tval, cur_pc, stvec, sepc;
  logic [4:0]  exc_cause;
  logic        flush_req, flush_ack, trap_set, trap_is_irq, do_sret;
  logic        redirect_valid, redirect_ready, busy;
  logic [4:0]  trap_scause;
  logic [31:0] trap_sepc, trap_stval, redirect_pc;

  trap_sequencer #(.IRQ_SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cur_priv(cur_priv), .sstatus_sie(sstatus_sie), .sie(sie),
    .sip_ssip(sip_ssip), .time_value(time_value), .stimecmp(stimecmp),
    .irq_ext_async(irq_ext_async), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .cur_pc(cur_pc), .sret_req(sret_req),
    .stvec(stvec), .sepc(sepc), .flush_req(flush_req), .flush_ack(flush_ack),
    .trap_set(trap_set), .trap_is_irq(trap_is_irq), .trap_scause(trap_scause),
    .trap_sepc(trap_sepc), .trap_stval(trap_stval), .do_sret(do_sret),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_chk = 0;
  int n_trap, n_sret, n_mutex = 0;
  logic [4:0]  cap_cause;
  logic [31:0] cap_sepc, cap_stval, cap_rpc;
  logic        cap_irq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (trap_set) begin
      n_trap++; cap_cause = trap_scause; cap_sepc = trap_sepc;
      cap_stval = trap_stval; cap_irq = trap_is_irq;
    end
    if (do_sret) n_sret++;
    if (redirect_valid) cap_rpc = redirect_pc;
    if (int'(trap_set) + int'(do_sret) + int'(flush_req) + int'(redirect_valid) > 1) n_mutex++;
    if (!busy && (trap_set | do_sret | flush_req | redirect_valid)) n_mutex++;
  endtask

  task automatic clr_cnt();
    n_trap = 0; n_sret = 0; cap_cause = '0; cap_sepc = '0; cap_stval = '0;
    cap_irq = 1'b0; cap_rpc = '0;
  endtask

  task automatic wait_trap();
    int k = 0;
    while (n_trap == 0 && n_sret == 0 && k < 30) begin tick(); k++; end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 40) begin tick(); k++; end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    int cnt;
    logic [31:0] rpc0;
    rst = 1'b1; cur_priv = PRIV_M; sstatus_sie = 0; sie = '0; sip_ssip = 0;
    time_value = '0; stimecmp = 32'hFFFF_FFFF; irq_ext_async = 0; exc_valid = 0;
    exc_cause = '0; exc_pc = '0; exc_tval = '0; cur_pc = 32'h2000; sret_req = 0;
    stvec = 32'h8000_0103; sepc = 32'h4000_0040; flush_ack = 1; redirect_ready = 1;
    clr_cnt();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {flush_req, trap_set, do_sret, redirect_valid, trap_is_irq}, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_scause", trap_scause, 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Exception with minimum latency
    clr_cnt();
    exc_valid = 1; exc_cause = 5'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    tick(); exc_valid = 0;
    chk("exc_n1_flush", flush_req, 1);
    chk("exc_n1_trap", trap_set, 0);
    tick();
    chk("exc_n2_trap", trap_set, 1);
    chk("exc_scause", trap_scause, 2);
    chk("exc_sepc", trap_sepc, 32'h100);
    chk("exc_stval", trap_stval, 32'hDEAD);
    chk("exc_is_irq", trap_is_irq, 0);
    tick();
    chk("exc_n3_rv", redirect_valid, 1);
    chk("exc_rpc", redirect_pc, 32'h8000_0100);
    tick();
    chk("exc_idle", busy, 0);
    chk("exc_ntrap", n_trap, 1);

    // External interrupt beats software interrupt once synchronized
    sstatus_sie = 1; sie = 32'h222; sip_ssip = 1; time_value = 5; stimecmp = 5;
    irq_ext_async = 1;
    repeat (3) tick();
    clr_cnt(); cur_priv = PRIV_S;
    wait_trap(); cur_priv = PRIV_M;
    chk("sei_cause", cap_cause, 9);
    chk("sei_irq", cap_irq, 1);
    chk("sei_sepc", cap_sepc, 32'h2000);
    chk("sei_stval", cap_stval, 0);
    wait_idle("sei_idle");
    irq_ext_async = 0;
    repeat (3) tick();
    clr_cnt(); cur_priv = PRIV_S;
    wait_trap(); cur_priv = PRIV_M;
    chk("ssi_cause", cap_cause, 1);
    chk("ssi_irq", cap_irq, 1);
    wait_idle("ssi_idle");
    sip_ssip = 0;

    // Timer: masked in S with sie off, taken in U
    sstatus_sie = 0; sie = 32'h20; time_value = 10; stimecmp = 5;
    clr_cnt(); cur_priv = PRIV_S; cnt = 0;
    repeat (8) begin tick(); if (busy) cnt++; end
    chk("sti_masked", cnt, 0);
    cur_priv = PRIV_U;
    wait_trap(); cur_priv = PRIV_M;
    chk("sti_cause", cap_cause, 5);
    chk("sti_ntrap", n_trap, 1);
    wait_idle("sti_idle");
    time_value = 4; cur_priv = PRIV_U; cnt = 0;
    repeat (6) begin tick(); if (busy) cnt++; end
    chk("sti_below", cnt, 0);
    cur_priv = PRIV_M; sie = '0;

    // Exception wins over simultaneous SRET
    clr_cnt();
    exc_valid = 1; exc_cause = 5'd13; exc_pc = 32'h200; sret_req = 1;
    tick(); exc_valid = 0; sret_req = 0;
    wait_idle("excsret_idle");
    chk("excsret_ntrap", n_trap, 1);
    chk("excsret_nsret", n_sret, 0);
    chk("excsret_cause", cap_cause, 13);

    // SRET alone
    clr_cnt();
    sret_req = 1; tick(); sret_req = 0;
    wait_idle("sret_idle");
    chk("sret_nsret", n_sret, 1);
    chk("sret_ntrap", n_trap, 0);
    chk("sret_rpc", cap_rpc, 32'h4000_0040);

    // Back-pressure on both handshakes
    clr_cnt(); flush_ack = 0;
    exc_valid = 1; exc_cause = 5'd7; exc_pc = 32'h300; tick(); exc_valid = 0;
    cnt = 0;
    repeat (10) begin if (flush_req) cnt++; tick(); end
    chk("stall_flush", cnt, 10);
    chk("stall_notrap", n_trap, 0);
    flush_ack = 1; redirect_ready = 0;
    tick(); tick();
    rpc0 = redirect_pc;
    chk("stall_rpc", rpc0, 32'h8000_0100);
    cnt = 0;
    repeat (5) begin if (redirect_valid && redirect_pc == rpc0) cnt++; tick(); end
    chk("stall_rv", cnt, 5);
    chk("stall_ntrap", n_trap, 1);
    redirect_ready = 1;
    wait_idle("stall_idle");

    // Reset in the middle of FLUSH
    clr_cnt(); flush_ack = 0;
    exc_valid = 1; exc_cause = 5'd4; exc_pc = 32'h400; exc_tval = 32'h44; tick(); exc_valid = 0;
    chk("rstmid_flush", flush_req, 1);
    rst = 1'b1; #1;
    chk("rstmid_outs", {flush_req, trap_set, do_sret, redirect_valid, busy}, 0);
    chk("rstmid_trapv", {trap_scause, trap_sepc[7:0], trap_stval[7:0]}, 0);
    @(negedge clk) rst = 1'b0;
    flush_ack = 1;
    repeat (10) tick();
    chk("rstmid_ntrap", n_trap, 0);
    chk("mutex", n_mutex, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
